move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; cycles the side to move may idle in WAIT_MOVE (used only with MOVE_TIMEOUT_EN).
REQ-002 clk  input  1  clock, rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  pulse; begins a game from IDLE or GAME_OVER.
REQ-005 first_comp  input  1  sampled on accepted start; 1 = computer moves first.
REQ-006 pl_valid / pl_pos  input  1 / 4  player move request, cell index 0..8.
REQ-007 pl_ready  output  1  player move accepted this cycle when pl_valid also high.
REQ-008 pc_valid / pc_pos / pc_ready  input / input / output  1 / 4 / 1  computer port, same rules.
REQ-009 occ  input  9  occupied-cell flags from board registers.
REQ-010 win / full  input  1 / 1  board winner and board-full flags from detectors.
REQ-011 wr_en / wr_cell / wr_mark  output  1 / 9 / 2  board write strobe, one-hot cell, mark (01 player, 10 computer).
REQ-012 clr_board  output  1  one-cycle pulse clearing board registers.
REQ-013 illegal  output  1  one-cycle pulse on a rejected move.
REQ-014 turn  output  2  side to move: 01 player, 10 computer, 00 none.
REQ-015 game_over / result  output  1 / 2  result: 00 none, 01 player, 10 computer, 11 draw.
REQ-016 timeout  output  1  one-cycle pulse on move timeout.

Function
REQ-017 States SHALL be IDLE, WAIT_MOVE, COMMIT, CHECK, GAME_OVER.
REQ-018 start in IDLE or GAME_OVER SHALL, next edge: pulse clr_board, clear result, load turn from first_comp, enter WAIT_MOVE; start in any other state SHALL be ignored.
REQ-019 pl_ready SHALL be high only in WAIT_MOVE with turn=01; pc_ready only in WAIT_MOVE with turn=10; valid on the other port SHALL be ignored.
REQ-020 Handshake (valid & ready) with pos>8 or occ[pos]=1 SHALL pulse illegal the next cycle, stay in WAIT_MOVE, keep turn, no write.
REQ-021 Legal handshake SHALL enter COMMIT; wr_en high exactly the one COMMIT cycle with wr_cell=one-hot(pos), wr_mark=turn.
REQ-022 CHECK (cycle after COMMIT) SHALL sample win and full: win -> GAME_OVER, result=mover; else full -> GAME_OVER, result=11; else toggle turn, return to WAIT_MOVE.
REQ-023 win SHALL take priority over full when both high.
REQ-024 Latency: handshake to wr_en 1 cycle; handshake to next ready 3 cycles.
REQ-025 In GAME_OVER: game_over=1, turn=00, result held, both ready low until start.
REQ-026 wr_en, wr_cell, wr_mark SHALL be 0 outside COMMIT.

Reset
REQ-027 reset SHALL force IDLE, turn=00, result=00, game_over=0, all strobes/readies 0, timeout counter 0, asynchronously.
REQ-028 reset mid-game SHALL abandon the move in flight with no write; board clearing relies on the board's own reset.

Configuration
REQ-029 With MOVE_TIMEOUT_EN defined: counter clears on each WAIT_MOVE entry, increments per WAIT_MOVE cycle; reaching TIMEOUT_CYCLES without legal handshake SHALL pulse timeout and enter GAME_OVER with result = opponent of turn; illegal moves do not clear the counter.
REQ-030 Without MOVE_TIMEOUT_EN: no counter, timeout tied 0, WAIT_MOVE waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-031 Package ttt_pkg SHALL hold state enum, mark codes (EMPTY 00, PLAYER 01, COMP 10), result codes, NUM_CELLS=9.
REQ-032 Sub-module move_decode SHALL map 4-bit pos to 9-bit one-hot plus in_range flag; instantiated once on the muxed accepted position.

Verification
REQ-033 reset, start with first_comp=0, pl_pos=4 valid -> wr_en 1 cycle later, wr_cell=9'h010, wr_mark=01; pc_ready high 3 cycles after handshake.
REQ-034 occ[4]=1, pc_pos=4 valid -> illegal pulse, no wr_en, turn stays 10; then pc_pos=0 -> wr_cell=9'h001, wr_mark=10.
REQ-035 pc_pos=11 -> illegal pulse, no write; pl_valid during computer turn -> pl_ready stays 0.
REQ-036 win=1 and full=1 in CHECK after player move -> game_over=1, result=01; start -> clr_board pulse, result=00.
REQ-037 full=1, win=0 in CHECK -> result=11; start during WAIT_MOVE -> ignored.
REQ-038 MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, player idle 8 cycles -> timeout pulse, result=10; without macro, 100 idle cycles -> still WAIT_MOVE, timeout=0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe move sequencer: FSM states, mark and
// result codes, board size.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_COMMIT,
    S_CHECK,
    S_GAME_OVER
  } state_t;

  localparam logic [1:0] MARK_EMPTY  = 2'b00;
  localparam logic [1:0] MARK_PLAYER = 2'b01;
  localparam logic [1:0] MARK_COMP   = 2'b10;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_COMP   = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;

  // Side that moves after the given one; result codes share the mark encoding.
  function automatic logic [1:0] opponent(input logic [1:0] side);
    return (side == MARK_PLAYER) ? MARK_COMP : MARK_PLAYER;
  endfunction

endpackage

// File: rtl/move_decode.sv
// Cell index decoder: 4-bit position to one-hot board cell plus a flag that
// the index names a real cell (0..8).
module move_decode
  import ttt_pkg::*;
(
  input  logic [3:0]           pos,
  output logic [NUM_CELLS-1:0] onehot,
  output logic                 in_range
);

  always_comb begin
    in_range = (pos < 4'(NUM_CELLS));
    onehot   = '0;
    if (in_range) onehot = NUM_CELLS'(1) << pos;
  end

endmodule

// File: rtl/move_sequencer.sv
// Game-flow controller: arbitrates player/computer moves, validates them against
// the board, issues board writes and decides the result. Optional move timeout
// is enabled by defining MOVE_TIMEOUT_EN.
module move_sequencer
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 first_comp,
  input  logic                 pl_valid,
  input  logic [3:0]           pl_pos,
  output logic                 pl_ready,
  input  logic                 pc_valid,
  input  logic [3:0]           pc_pos,
  output logic                 pc_ready,
  input  logic [NUM_CELLS-1:0] occ,
  input  logic                 win,
  input  logic                 full,
  output logic                 wr_en,
  output logic [NUM_CELLS-1:0] wr_cell,
  output logic [1:0]           wr_mark,
  output logic                 clr_board,
  output logic                 illegal,
  output logic [1:0]           turn,
  output logic                 game_over,
  output logic [1:0]           result,
  output logic                 timeout
);

  state_t state, state_next;
  logic [1:0] turn_q, turn_next;
  logic [1:0] result_q, result_next;
  logic       illegal_q, illegal_next;
  logic       clr_q, clr_next;
  logic       timeout_hit;

  logic                 handshake;
  logic                 legal;
  logic [3:0]           sel_pos;
  logic [NUM_CELLS-1:0] sel_onehot;
  logic                 sel_in_range;
  logic [NUM_CELLS-1:0] cell_p1;

  assign pl_ready  = (state == S_WAIT_MOVE) && (turn_q == MARK_PLAYER);
  assign pc_ready  = (state == S_WAIT_MOVE) && (turn_q == MARK_COMP);
  assign handshake = (pl_valid && pl_ready) || (pc_valid && pc_ready);

  // Only the side to move can handshake, so its port drives the single decoder.
  assign sel_pos = (turn_q == MARK_COMP) ? pc_pos : pl_pos;

  move_decode u_decode (
    .pos      (sel_pos),
    .onehot   (sel_onehot),
    .in_range (sel_in_range)
  );

  assign legal = sel_in_range && ((sel_onehot & occ) == '0);

  always_comb begin
    state_next   = state;
    turn_next    = turn_q;
    result_next  = result_q;
    illegal_next = 1'b0;
    clr_next     = 1'b0;
    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          state_next  = S_WAIT_MOVE;
          clr_next    = 1'b1;
          result_next = RES_NONE;
          turn_next   = first_comp ? MARK_COMP : MARK_PLAYER;
        end
      end
      S_WAIT_MOVE: begin
        if (handshake && legal) begin
          state_next = S_COMMIT;
        end else begin
          illegal_next = handshake;
          if (timeout_hit) begin
            state_next  = S_GAME_OVER;
            result_next = opponent(turn_q);
            turn_next   = MARK_EMPTY;
          end
        end
      end
      S_COMMIT: state_next = S_CHECK;
      S_CHECK: begin
        if (win) begin
          state_next  = S_GAME_OVER;
          result_next = turn_q;
          turn_next   = MARK_EMPTY;
        end else if (full) begin
          state_next  = S_GAME_OVER;
          result_next = RES_DRAW;
          turn_next   = MARK_EMPTY;
        end else begin
          state_next = S_WAIT_MOVE;
          turn_next  = opponent(turn_q);
        end
      end
      default: begin
        state_next = S_IDLE;
        turn_next  = MARK_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      turn_q    <= MARK_EMPTY;
      result_q  <= RES_NONE;
      illegal_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state     <= state_next;
      turn_q    <= turn_next;
      result_q  <= result_next;
      illegal_q <= illegal_next;
      clr_q     <= clr_next;
    end
  end

  // Accepted cell, presented during COMMIT (data path, no reset)
  always_ff @(posedge clk) begin
    if (handshake && legal) cell_p1 <= sel_onehot;
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Counts cycles spent in the current WAIT_MOVE visit; illegal attempts keep counting.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_WAIT_MOVE && state_next == S_WAIT_MOVE) cnt_q <= cnt_q + CNT_W'(1);
      else cnt_q <= '0;
      timeout_q <= (state == S_WAIT_MOVE) && !(handshake && legal) && timeout_hit;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign wr_en     = (state == S_COMMIT);
  assign wr_cell   = wr_en ? cell_p1 : '0;
  assign wr_mark   = wr_en ? turn_q : MARK_EMPTY;
  assign clr_board = clr_q;
  assign illegal   = illegal_q;
  assign turn      = turn_q;
  assign game_over = (state == S_GAME_OVER);
  assign result    = result_q;

endmodule
